// File: rtl/axis_demux_1_2.sv
// axis_demux_1_2: 1:2 AXI-Stream packet demux; route sampled on the first beat and locked until tlast.
// Optional per-output packet counters are enabled by defining AXIS_DEMUX_PKT_CNT_EN.
module axis_demux_1_2 #(
   parameter int DATA_W = 8
`ifdef AXIS_DEMUX_PKT_CNT_EN
   , parameter int CNT_W = 16
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sel,
   input  logic [DATA_W-1:0] s_tdata,
   input  logic              s_tvalid,
   output logic              s_tready,
   input  logic              s_tlast,
   output logic [DATA_W-1:0] m0_tdata,
   output logic              m0_tvalid,
   input  logic              m0_tready,
   output logic              m0_tlast,
   output logic [DATA_W-1:0] m1_tdata,
   output logic              m1_tvalid,
   input  logic              m1_tready,
   output logic              m1_tlast,
   output logic              busy
`ifdef AXIS_DEMUX_PKT_CNT_EN
   , output logic [CNT_W-1:0] pkt_cnt0
   , output logic [CNT_W-1:0] pkt_cnt1
`endif
);
   typedef enum logic {IDLE, PKT} state_t;
   state_t            state_q, state_d;
   logic              route_q, dest_q, dest_d, out_valid_q, out_last_q, sel_rdy, acc;
   logic [DATA_W-1:0] out_data_q;
   assign sel_rdy   = dest_q ? m1_tready : m0_tready;
   assign s_tready  = !out_valid_q || sel_rdy;
   assign acc       = s_tvalid && s_tready;
   assign dest_d    = (state_q == PKT) ? route_q : sel;
   assign state_d   = s_tlast ? IDLE : PKT;
   assign m0_tvalid = out_valid_q && !dest_q;
   assign m1_tvalid = out_valid_q && dest_q;
   assign m0_tdata  = out_data_q;
   assign m1_tdata  = out_data_q;
   assign m0_tlast  = out_last_q;
   assign m1_tlast  = out_last_q;
   assign busy      = (state_q == PKT);
   // Acceptance implies any held beat drains this cycle, so a reload never loses data.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         route_q     <= 1'b0;
         dest_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
      end else if (acc) begin
         state_q     <= state_d;
         route_q     <= dest_d;
         dest_q      <= dest_d;
         out_valid_q <= 1'b1;
         out_last_q  <= s_tlast;
         out_data_q  <= s_tdata;
      end else if (sel_rdy) begin
         out_valid_q <= 1'b0;
      end
   end
`ifdef AXIS_DEMUX_PKT_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pkt_cnt0 <= '0;
         pkt_cnt1 <= '0;
      end else begin
         if (m0_tvalid && m0_tready && out_last_q) pkt_cnt0 <= pkt_cnt0 + 1'b1;
         if (m1_tvalid && m1_tready && out_last_q) pkt_cnt1 <= pkt_cnt1 + 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_axis_demux_1_2.sv
// tb_axis_demux_1_2: directed vector table plus hand sequences for async reset and packet counters.
module tb_axis_demux_1_2;
   localparam int W = 8;
   localparam logic O = 1'b0, I = 1'b1;
   logic clk = 1'b0, reset = 1'b1, sel = 1'b0, s_tvalid = 1'b0, s_tlast = 1'b0;
   logic m0_tready = 1'b1, m1_tready = 1'b1;
   logic [W-1:0] s_tdata = '0;
   logic s_tready, m0_tvalid, m0_tlast, m1_tvalid, m1_tlast, busy;
   logic [W-1:0] m0_tdata, m1_tdata;
`ifdef AXIS_DEMUX_PKT_CNT_EN
   logic [3:0] pkt_cnt0, pkt_cnt1;
`endif
   int tests = 0, fails = 0;

   typedef struct {
      logic sel; logic [W-1:0] d; logic v, l, r0, r1;
      logic e0v, e1v; logic [W-1:0] ed; logic el, eb, er;
   } vec_t;
   vec_t vt[25];

   always #5 clk = ~clk;

   axis_demux_1_2 #(
      .DATA_W(W)
`ifdef AXIS_DEMUX_PKT_CNT_EN
      , .CNT_W(4)
`endif
   ) dut (
      .clk(clk), .reset(reset), .sel(sel),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
      .m0_tdata(m0_tdata), .m0_tvalid(m0_tvalid), .m0_tready(m0_tready), .m0_tlast(m0_tlast),
      .m1_tdata(m1_tdata), .m1_tvalid(m1_tvalid), .m1_tready(m1_tready), .m1_tlast(m1_tlast),
      .busy(busy)
`ifdef AXIS_DEMUX_PKT_CNT_EN
      , .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic s, input logic [W-1:0] d, input logic v, input logic l, input logic r0, input logic r1);
      sel = s; s_tdata = d; s_tvalid = v; s_tlast = l; m0_tready = r0; m1_tready = r1;
   endtask

   // {m0v,m1v,m0d,m0l,m1d,m1l,busy,s_tready}
   function automatic logic [31:0] obs();
      return {8'h0, m0_tvalid, m1_tvalid, m0_tdata, m0_tlast, m1_tdata, m1_tlast, busy, s_tready};
   endfunction

   initial begin
      // sel, data, valid, last, r0, r1 | m0v, m1v, data, last, busy, s_tready (after the edge)
      vt[0]  = '{O, 8'h22, I, O, I, I, I, O, 8'h22, O, I, I};
      vt[1]  = '{O, 8'h33, I, O, I, I, I, O, 8'h33, O, I, I};
      vt[2]  = '{O, 8'h44, I, I, I, I, I, O, 8'h44, I, O, I};
      vt[3]  = '{O, 8'h00, O, O, I, I, O, O, 8'h44, I, O, I};
      vt[4]  = '{I, 8'h55, I, O, I, I, O, I, 8'h55, O, I, I};
      vt[5]  = '{O, 8'h66, I, O, I, I, O, I, 8'h66, O, I, I};
      vt[6]  = '{I, 8'h77, I, I, I, I, O, I, 8'h77, I, O, I};
      vt[7]  = '{O, 8'h00, O, O, I, I, O, O, 8'h77, I, O, I};
      vt[8]  = '{O, 8'h12, I, O, I, I, I, O, 8'h12, O, I, I};
      for (int k = 9; k < 14; k++) vt[k] = '{O, 8'h56, I, O, O, I, I, O, 8'h12, O, I, O};
      vt[14] = '{I, 8'h56, I, O, I, I, I, O, 8'h56, O, I, I};
      vt[15] = '{I, 8'h90, I, I, I, I, I, O, 8'h90, I, O, I};
      vt[16] = '{O, 8'h00, O, O, I, I, O, O, 8'h90, I, O, I};
      vt[17] = '{O, 8'h11, I, I, I, I, I, O, 8'h11, I, O, I};
      vt[18] = '{I, 8'h88, I, I, I, I, O, I, 8'h88, I, O, I};
      vt[19] = '{O, 8'h00, O, O, I, I, O, O, 8'h88, I, O, I};
      vt[20] = '{O, 8'hAA, I, I, O, I, I, O, 8'hAA, I, O, O};
      vt[21] = '{I, 8'hBB, I, I, O, I, I, O, 8'hAA, I, O, O};
      vt[22] = '{I, 8'hBB, I, I, I, I, O, I, 8'hBB, I, O, I};
      vt[23] = '{O, 8'h00, O, O, I, O, O, I, 8'hBB, I, O, O};
      vt[24] = '{O, 8'h00, O, O, I, I, O, O, 8'hBB, I, O, I};

      #12 reset = 1'b0;
      #1 check("reset_state", obs(), {8'h0, O, O, 8'h00, O, 8'h00, O, O, I});
      @(posedge clk); #1;
      for (int i = 0; i < 25; i++) begin
         drive(vt[i].sel, vt[i].d, vt[i].v, vt[i].l, vt[i].r0, vt[i].r1);
         @(posedge clk); #1;
         check($sformatf("vec%0d", i), obs(),
               {8'h0, vt[i].e0v, vt[i].e1v, vt[i].ed, vt[i].el, vt[i].ed, vt[i].el, vt[i].eb, vt[i].er});
      end

      // Reset while a sel=1 packet is in flight; next beat must start a fresh packet.
      drive(I, 8'h33, I, O, I, I);
      @(posedge clk); #1;
      check("pre_reset", obs(), {8'h0, O, I, 8'h33, O, 8'h33, O, I, I});
      drive(O, 8'h00, O, O, I, I);
      #2 reset = 1'b1;
      #1 check("async_reset", {30'h0, m1_tvalid, busy}, 32'h0);
      #2 reset = 1'b0;
      drive(O, 8'h15, I, I, I, I);
      @(posedge clk); #1;
      check("post_reset_beat", obs(), {8'h0, I, O, 8'h15, I, 8'h15, I, O, I});
      drive(O, 8'h00, O, O, I, I);
      @(posedge clk); #1;

`ifdef AXIS_DEMUX_PKT_CNT_EN
      drive(O, 8'h01, I, I, I, I);
      @(posedge clk); #1;
      drive(I, 8'h02, I, I, I, I);
      @(posedge clk); #1;
      drive(O, 8'h00, O, O, I, I);
      @(posedge clk); #1;
      check("pkt_cnt0", {28'h0, pkt_cnt0}, 32'd2);
      check("pkt_cnt1", {28'h0, pkt_cnt1}, 32'd1);
      for (int k = 0; k < 14; k++) begin
         drive(O, k[7:0], I, I, I, I);
         @(posedge clk); #1;
      end
      drive(O, 8'h00, O, O, I, I);
      @(posedge clk); #1;
      check("pkt_cnt0_wrap", {28'h0, pkt_cnt0}, 32'd0);
      check("pkt_cnt1_hold", {28'h0, pkt_cnt1}, 32'd1);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
